// File: rtl/candy_regwr_arb.sv
// candy_regwr_arb
//   Arbiter and sequencer for the single write port of the candy register file.
//   Two writeback sources each feed a one-entry holding buffer through a
//   valid/ready handshake. Buffered writes are issued one per cycle on the
//   registered we/waddr/wdata port. pend_mask tells decode which registers still
//   have a write outstanding.
//
//   Build option: CANDY_REGWR_RR_EN
//     defined   - round-robin tie break (requester that did not win last time)
//     undefined - fixed priority, requester A always wins a tie
//
//   Ports
//     clk              system clock, rising edge
//     rst              synchronous active-low reset
//     a_vld/a_rdy      requester A (execute writeback) handshake
//     a_addr/a_data    requester A destination register / data
//     b_vld/b_rdy      requester B (load writeback) handshake
//     b_addr/b_data    requester B destination register / data
//     we/waddr/wdata   registered register file write port
//     pend_mask        bit i set while a write to register i is buffered or issuing
//     busy             any buffer valid or a write issuing
module candy_regwr_arb #(
   parameter int DW = 24,
   parameter int AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_vld,
   output logic              a_rdy,
   input  logic [AW-1:0]     a_addr,
   input  logic [DW-1:0]     a_data,
   input  logic              b_vld,
   output logic              b_rdy,
   input  logic [AW-1:0]     b_addr,
   input  logic [DW-1:0]     b_data,
   output logic              we,
   output logic [AW-1:0]     waddr,
   output logic [DW-1:0]     wdata,
   output logic [2**AW-1:0]  pend_mask,
   output logic              busy
);

   localparam int NR = 2**AW;

   logic          buf_vld_a_r;
   logic [AW-1:0] buf_addr_a_r;
   logic [DW-1:0] buf_data_a_r;
   logic          buf_vld_b_r;
   logic [AW-1:0] buf_addr_b_r;
   logic [DW-1:0] buf_data_b_r;
   logic          we_r;
   logic [AW-1:0] waddr_r;
   logic [DW-1:0] wdata_r;
   logic          grant_a_s;
   logic          grant_b_s;
`ifdef CANDY_REGWR_RR_EN
   logic          last_grant_r;   // 1'b1 = B won the most recent grant
`endif

   // Arbitration over buffer valids only; new inputs never bypass a buffer.
   always_comb begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
      if (buf_vld_a_r && buf_vld_b_r) begin
`ifdef CANDY_REGWR_RR_EN
         grant_a_s = last_grant_r;
         grant_b_s = ~last_grant_r;
`else
         grant_a_s = 1'b1;
         grant_b_s = 1'b0;
`endif
      end else begin
         grant_a_s = buf_vld_a_r;
         grant_b_s = buf_vld_b_r;
      end
   end

   // A granted buffer drains this cycle, so it may refill at the same edge.
   // Ready never looks at the requester's valid, keeping the handshake loop-free.
   assign a_rdy = rst & (~buf_vld_a_r | grant_a_s);
   assign b_rdy = rst & (~buf_vld_b_r | grant_b_s);

   // Holding buffers: load on accept, release on grant, drop on reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         buf_vld_a_r  <= 1'b0;
         buf_addr_a_r <= {AW{1'b0}};
         buf_data_a_r <= {DW{1'b0}};
         buf_vld_b_r  <= 1'b0;
         buf_addr_b_r <= {AW{1'b0}};
         buf_data_b_r <= {DW{1'b0}};
      end else begin
         if (a_vld && a_rdy) begin
            buf_vld_a_r  <= 1'b1;
            buf_addr_a_r <= a_addr;
            buf_data_a_r <= a_data;
         end else if (grant_a_s) begin
            buf_vld_a_r  <= 1'b0;
         end else begin
            buf_vld_a_r  <= buf_vld_a_r;
         end
         if (b_vld && b_rdy) begin
            buf_vld_b_r  <= 1'b1;
            buf_addr_b_r <= b_addr;
            buf_data_b_r <= b_data;
         end else if (grant_b_s) begin
            buf_vld_b_r  <= 1'b0;
         end else begin
            buf_vld_b_r  <= buf_vld_b_r;
         end
      end
   end

   // Write port register: a pulse per grant; address/data hold when idle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         we_r    <= 1'b0;
         waddr_r <= {AW{1'b0}};
         wdata_r <= {DW{1'b0}};
      end else begin
         we_r <= grant_a_s | grant_b_s;
         if (grant_a_s) begin
            waddr_r <= buf_addr_a_r;
            wdata_r <= buf_data_a_r;
         end else if (grant_b_s) begin
            waddr_r <= buf_addr_b_r;
            wdata_r <= buf_data_b_r;
         end else begin
            waddr_r <= waddr_r;
            wdata_r <= wdata_r;
         end
      end
   end

`ifdef CANDY_REGWR_RR_EN
   // Remember the most recent winner; reset to B so A takes the first tie.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_grant_r <= 1'b1;
      end else if (grant_a_s) begin
         last_grant_r <= 1'b0;
      end else if (grant_b_s) begin
         last_grant_r <= 1'b1;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end
`endif

   // Pending mask: union of both buffers and the write currently on the port.
   always_comb begin
      pend_mask = {NR{1'b0}};
      for (int i = 0; i < NR; i++) begin
         if ((buf_vld_a_r && (buf_addr_a_r == AW'(i))) ||
             (buf_vld_b_r && (buf_addr_b_r == AW'(i))) ||
             (we_r && (waddr_r == AW'(i)))) begin
            pend_mask[i] = 1'b1;
         end else begin
            pend_mask[i] = 1'b0;
         end
      end
   end

   assign we    = we_r;
   assign waddr = waddr_r;
   assign wdata = wdata_r;
   assign busy  = buf_vld_a_r | buf_vld_b_r | we_r;

endmodule

// File: tb/tb_candy_regwr_arb.sv
// tb_candy_regwr_arb
//   Self-checking bench for candy_regwr_arb. Expected writes are queued in
//   expected grant order as stimulus is driven; a monitor pops and compares on
//   every we pulse and keeps a model of the register file.
module tb_candy_regwr_arb;

   localparam int DW = 24;
   localparam int AW = 4;

   logic            clk;
   logic            rst;
   logic            a_vld;
   logic            a_rdy;
   logic [AW-1:0]   a_addr;
   logic [DW-1:0]   a_data;
   logic            b_vld;
   logic            b_rdy;
   logic [AW-1:0]   b_addr;
   logic [DW-1:0]   b_data;
   logic            we;
   logic [AW-1:0]   waddr;
   logic [DW-1:0]   wdata;
   logic [15:0]     pend_mask;
   logic            busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [AW+DW-1:0] sb_q[$];
   logic [DW-1:0]    rf [16];

   candy_regwr_arb #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_vld     (a_vld),
      .a_rdy     (a_rdy),
      .a_addr    (a_addr),
      .a_data    (a_data),
      .b_vld     (b_vld),
      .b_rdy     (b_rdy),
      .b_addr    (b_addr),
      .b_data    (b_data),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .pend_mask (pend_mask),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every write pulse must match the next expected write.
   always @(negedge clk) begin
      if (we === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_we", {28'd0, waddr}, 32'hffff_ffff);
         end else begin
            logic [AW+DW-1:0] e;
            e = sb_q.pop_front();
            check("wr_addr", 32'(waddr), 32'(e[AW+DW-1:DW]));
            check("wr_data", 32'(wdata), 32'(e[DW-1:0]));
            rf[waddr] = wdata;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rf[i] = 24'd0;
      rst = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
      a_addr = 4'd0; a_data = 24'd0; b_addr = 4'd0; b_data = 24'd0;
      idle(2);
      // reset state
      check("rst_we", 32'(we), 32'd0);
      check("rst_waddr", 32'(waddr), 32'd0);
      check("rst_wdata", 32'(wdata), 32'd0);
      check("rst_pend", 32'(pend_mask), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_a_rdy", 32'(a_rdy), 32'd0);
      check("rst_b_rdy", 32'(b_rdy), 32'd0);
      rst = 1'b1;
      #1;
      check("a_rdy_idle", 32'(a_rdy), 32'd1);
      check("b_rdy_idle", 32'(b_rdy), 32'd1);

      // single write with exact latency and pend window
      a_vld = 1'b1; a_addr = 4'd3; a_data = 24'h5a0024;
      sb_q.push_back({4'd3, 24'h5a0024});
      @(negedge clk);
      a_vld = 1'b0;
      check("single_we_early", 32'(we), 32'd0);
      check("single_pend_buf", 32'(pend_mask), 32'h0008);
      check("single_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("single_we", 32'(we), 32'd1);
      check("single_pend_we", 32'(pend_mask), 32'h0008);
      @(negedge clk);
      check("single_we_width", 32'(we), 32'd0);
      check("single_pend_clr", 32'(pend_mask), 32'd0);
      check("single_waddr_hold", 32'(waddr), 32'd3);
      check("single_busy_clr", 32'(busy), 32'd0);
      check("single_rf3", 32'(rf[3]), 32'h5a0024);

      // solo B write to register 0 (leaves B as most recent winner)
      b_vld = 1'b1; b_addr = 4'd0; b_data = 24'h0c0c0c;
      sb_q.push_back({4'd0, 24'h0c0c0c});
      @(negedge clk);
      b_vld = 1'b0;
      check("addr0_pend", 32'(pend_mask), 32'h0001);
      idle(3);
      check("addr0_rf", 32'(rf[0]), 32'h0c0c0c);

      // tie, then A refills while B still waits: a second tie
      a_vld = 1'b1; a_addr = 4'd1; a_data = 24'h124b36;
      b_vld = 1'b1; b_addr = 4'd2; b_data = 24'h655356;
      sb_q.push_back({4'd1, 24'h124b36});
`ifdef CANDY_REGWR_RR_EN
      sb_q.push_back({4'd2, 24'h655356});
`endif
      @(negedge clk);
      check("tie_pend", 32'(pend_mask), 32'h0006);
      check("tie_a_rdy", 32'(a_rdy), 32'd1);
      check("tie_b_rdy", 32'(b_rdy), 32'd0);
      b_vld = 1'b0;
      a_addr = 4'd5; a_data = 24'h00a5a5;
      sb_q.push_back({4'd5, 24'h00a5a5});
`ifndef CANDY_REGWR_RR_EN
      sb_q.push_back({4'd2, 24'h655356});
`endif
      @(negedge clk);
      a_vld = 1'b0;
      check("tie_first_addr", 32'(waddr), 32'd1);
      idle(4);
      check("tie_idle", 32'(busy), 32'd0);

      // back-to-back from A with no bubbles
      a_vld = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check("b2b_a_rdy", 32'(a_rdy), 32'd1);
         a_addr = AW'(i); a_data = 24'h100000 + DW'(i);
         sb_q.push_back({AW'(i), 24'h100000 + DW'(i)});
         @(negedge clk);
         if (i > 1) check("b2b_we", 32'(we), 32'd1);
      end
      a_vld = 1'b0;
      @(negedge clk);
      check("b2b_we_last", 32'(we), 32'd1);
      check("b2b_waddr_last", 32'(waddr), 32'd4);
      @(negedge clk);
      check("b2b_we_end", 32'(we), 32'd0);
      idle(1);

      // same address from both on one edge
      a_vld = 1'b1; a_addr = 4'd4; a_data = 24'h000001;
      b_vld = 1'b1; b_addr = 4'd4; b_data = 24'h5a0034;
`ifdef CANDY_REGWR_RR_EN
      sb_q.push_back({4'd4, 24'h5a0034});
      sb_q.push_back({4'd4, 24'h000001});
`else
      sb_q.push_back({4'd4, 24'h000001});
      sb_q.push_back({4'd4, 24'h5a0034});
`endif
      @(negedge clk);
      a_vld = 1'b0; b_vld = 1'b0;
      check("same_pend_buf", 32'(pend_mask), 32'h0010);
      @(negedge clk);
      check("same_pend_w1", 32'(pend_mask), 32'h0010);
      @(negedge clk);
      check("same_pend_w2", 32'(pend_mask), 32'h0010);
      @(negedge clk);
      check("same_pend_clr", 32'(pend_mask), 32'd0);
`ifdef CANDY_REGWR_RR_EN
      check("same_rf4", 32'(rf[4]), 32'h000001);
`else
      check("same_rf4", 32'(rf[4]), 32'h5a0034);
`endif

      // make B the most recent winner so it loses the next tie in either mode
      b_vld = 1'b1; b_addr = 4'd12; b_data = 24'h0c0c0c;
      sb_q.push_back({4'd12, 24'h0c0c0c});
      @(negedge clk);
      b_vld = 1'b0;
      idle(3);

      // backpressure on B while it loses
      a_vld = 1'b1; a_addr = 4'd7; a_data = 24'h777777;
      b_vld = 1'b1; b_addr = 4'd6; b_data = 24'h666666;
      sb_q.push_back({4'd7, 24'h777777});
      sb_q.push_back({4'd6, 24'h666666});
      @(negedge clk);
      check("bp_b_rdy_low", 32'(b_rdy), 32'd0);
      a_vld = 1'b0;
      b_addr = 4'd9; b_data = 24'habcdef;
      sb_q.push_back({4'd9, 24'habcdef});
      @(negedge clk);
      check("bp_b_rdy_high", 32'(b_rdy), 32'd1);
      check("bp_first_addr", 32'(waddr), 32'd7);
      @(negedge clk);
      b_vld = 1'b0;
      check("bp_second_addr", 32'(waddr), 32'd6);
      @(negedge clk);
      check("bp_third_data", 32'(wdata), 32'habcdef);
      idle(2);
      check("bp_rf6", 32'(rf[6]), 32'h666666);
      check("bp_rf9", 32'(rf[9]), 32'habcdef);

      // reset with both buffers full
      a_vld = 1'b1; a_addr = 4'd10; a_data = 24'h0a0a0a;
      b_vld = 1'b1; b_addr = 4'd11; b_data = 24'h0b0b0b;
      @(negedge clk);
      check("mid_pend_full", 32'(pend_mask), 32'h0c00);
      rst = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
      @(negedge clk);
      check("mid_we", 32'(we), 32'd0);
      check("mid_pend", 32'(pend_mask), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_a_rdy", 32'(a_rdy), 32'd0);
      rst = 1'b1;
      idle(4);
      check("mid_rf10", 32'(rf[10]), 32'd0);
      check("mid_rf11", 32'(rf[11]), 32'd0);
      check("mid_idle", 32'(busy), 32'd0);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
